regfile_seq_ctrl: RTL and testbench

//  Sequencer for the 8x8 register file and its external ALU. Accepts 16-bit

---
 rtl/regfile_seq_ctrl.sv | 122 ++++++++++++
 tb/tb_regfile_seq_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_seq_ctrl.sv
// Sequencer for an 8x8 register file plus external ALU: zero-fills the file
// after reset, then runs one accepted instruction at a time through EXEC and WB.
module regfile_seq_ctrl #(
  parameter int DW         = 8,
  parameter int AW         = 3,
  parameter int INIT_CLEAR = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  input  logic [DW-1:0] alu_result,
  output logic [AW-1:0] DA,
  output logic [AW-1:0] AA,
  output logic [AW-1:0] BA,
  output logic          RW,
  output logic [DW-1:0] wr_data,
  output logic [2:0]    alu_fs,
  output logic          busy,
  output logic          done,
  output logic          illegal
);

  localparam int NREG = 2**AW;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_EXEC, S_WB} state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDI = 4'd1;
  localparam logic [3:0] OP_MOV = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd7;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] da;
    logic [2:0] aa;
    logic [2:0] ba;
    logic [2:0] lo;
  } instr_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  instr_t          ir;
  logic [DW-1:0]   res;
  logic [7:0]      imm;
  logic            op_illegal;

  assign imm        = {ir.aa[1:0], ir.ba, ir.lo};
  assign op_illegal = ir.op[3];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if (INIT_CLEAR != 0) state <= S_INIT;
      else                 state <= S_IDLE;
      cnt <= '0;
      ir  <= '0;
      res <= '0;
    end else begin
      case (state)
        S_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(NREG-1)) state <= S_IDLE;
        end
        S_IDLE: begin
          if (instr_valid) begin
            ir    <= instr_t'(instr);
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          res <= (ir.op == OP_LDI) ? DW'(imm) : alu_result;
          if (ir.op == OP_NOP || op_illegal) state <= S_IDLE;
          else                               state <= S_WB;
        end
        S_WB:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state; the reset term forces the quiet
  // reset-held values even though the state register already sits in INIT.
  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b1;
    RW          = 1'b0;
    DA          = '0;
    AA          = '0;
    BA          = '0;
    wr_data     = '0;
    alu_fs      = 3'd0;
    done        = 1'b0;
    illegal     = 1'b0;
    if (reset) begin
      busy = (state != S_IDLE);
      case (state)
        S_INIT: begin
          RW = 1'b1;
          DA = cnt;
        end
        S_IDLE: instr_ready = 1'b1;
        S_EXEC: begin
          AA = AW'(ir.aa);
          BA = AW'(ir.ba);
          if (ir.op >= OP_ADD && ir.op <= OP_XOR) alu_fs = 3'(ir.op - OP_MOV);
          done    = (ir.op == OP_NOP);
          illegal = op_illegal;
        end
        S_WB: begin
          RW      = 1'b1;
          DA      = AW'(ir.da);
          wr_data = res;
          done    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// Directed bench for regfile_seq_ctrl with a small register-file/ALU model
// wrapped around it; expected write data is hand-computed.
module tb_regfile_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_result;
  logic [2:0]  DA, AA, BA;
  logic        RW;
  logic [7:0]  wr_data;
  logic [2:0]  alu_fs;
  logic        busy, done, illegal;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int done_cyc;

  logic [7:0] rf [8];

  regfile_seq_ctrl #(.DW(8), .AW(3), .INIT_CLEAR(1)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_result(alu_result), .DA(DA), .AA(AA), .BA(BA), .RW(RW),
    .wr_data(wr_data), .alu_fs(alu_fs), .busy(busy), .done(done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // datapath model: register file written by the controller, ALU reading it
  always @(posedge clk) if (RW) rf[DA] <= wr_data;

  always_comb begin
    case (alu_fs)
      3'd0:    alu_result = rf[AA];
      3'd1:    alu_result = rf[AA] + rf[BA];
      3'd2:    alu_result = rf[AA] - rf[BA];
      3'd3:    alu_result = rf[AA] & rf[BA];
      3'd4:    alu_result = rf[AA] | rf[BA];
      3'd5:    alu_result = rf[AA] ^ rf[BA];
      default: alu_result = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] d,
                                      input logic [2:0] a, input logic [2:0] b);
    return {op, d, a, b, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] d, input logic [7:0] imm);
    return {4'h1, d, 1'b0, imm};
  endfunction

  // called right after reset release, inside the first INIT cycle
  task automatic chk_init();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      chk("init_rw", RW, 1);
      chk("init_da", DA, k);
      chk("init_wd", wr_data, 0);
      chk("init_rdy", instr_ready, 0);
    end
    @(negedge clk);
    chk("init_end_rdy", instr_ready, 1);
    chk("init_end_busy", busy, 0);
    chk("init_end_rw", RW, 0);
  endtask

  // called in an IDLE cycle; returns in the IDLE cycle after WB
  task automatic run_wr(input string tag, input logic [15:0] w, input bit chk_ab,
                        input logic [2:0] ea, input logic [2:0] eb, input logic [2:0] efs,
                        input logic [2:0] eda, input logic [7:0] edata);
    chk({tag, "_rdy"}, instr_ready, 1);
    instr       = w;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr       = 16'hFFFF;
    chk({tag, "_ex_busy"}, busy, 1);
    chk({tag, "_ex_rw"}, RW, 0);
    chk({tag, "_ex_fs"}, alu_fs, efs);
    chk({tag, "_ex_done"}, done, 0);
    if (chk_ab) begin
      chk({tag, "_ex_aa"}, AA, ea);
      chk({tag, "_ex_ba"}, BA, eb);
    end
    @(negedge clk);
    chk({tag, "_wb_rw"}, RW, 1);
    chk({tag, "_wb_da"}, DA, eda);
    chk({tag, "_wb_data"}, wr_data, edata);
    chk({tag, "_wb_done"}, done, 1);
    done_cyc = cyc;
    @(negedge clk);
  endtask

  initial begin
    int t1, idx, acc_n, wr_n;
    bit prev;
    logic [15:0] q [4];
    logic [7:0]  qd [4];

    reset       = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_rw", RW, 0);
    chk("rst_busy", busy, 1);
    chk("rst_rdy", instr_ready, 0);
    chk("rst_da", DA, 0);
    chk("rst_done", done, 0);
    chk("rst_ill", illegal, 0);

    reset = 1'b1;
    #1;
    chk_init();

    run_wr("ldi_r3", ldi(3'd3, 8'hA5), 0, 0, 0, 3'd0, 3'd3, 8'hA5);
    t1 = done_cyc;
    run_wr("mov_r5", rr(4'd2, 3'd5, 3'd3, 3'd0), 1, 3'd3, 3'd0, 3'd0, 3'd5, 8'hA5);
    chk("done_spacing", done_cyc - t1, 3);

    run_wr("ldi_r1", ldi(3'd1, 8'hF0), 0, 0, 0, 3'd0, 3'd1, 8'hF0);
    run_wr("ldi_r2", ldi(3'd2, 8'h20), 0, 0, 0, 3'd0, 3'd2, 8'h20);
    run_wr("add",    rr(4'd3, 3'd4, 3'd1, 3'd2), 1, 3'd1, 3'd2, 3'd1, 3'd4, 8'h10);
    run_wr("sub",    rr(4'd4, 3'd6, 3'd2, 3'd1), 1, 3'd2, 3'd1, 3'd2, 3'd6, 8'h30);
    run_wr("and",    rr(4'd5, 3'd0, 3'd1, 3'd2), 1, 3'd1, 3'd2, 3'd3, 3'd0, 8'h20);
    run_wr("or",     rr(4'd6, 3'd7, 3'd1, 3'd2), 1, 3'd1, 3'd2, 3'd4, 3'd7, 8'hF0);
    run_wr("xor",    rr(4'd7, 3'd7, 3'd1, 3'd2), 1, 3'd1, 3'd2, 3'd5, 3'd7, 8'hD0);
    run_wr("raw",    rr(4'd3, 3'd3, 3'd7, 3'd4), 1, 3'd7, 3'd4, 3'd1, 3'd3, 8'hE0);

    // illegal opcode: one-cycle pulse, no write, back to IDLE
    instr = rr(4'hB, 3'd1, 3'd1, 3'd1); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("ill_pulse", illegal, 1);
    chk("ill_done", done, 0);
    chk("ill_rw", RW, 0);
    @(negedge clk);
    chk("ill_end", illegal, 0);
    chk("ill_rw2", RW, 0);
    chk("ill_rdy", instr_ready, 1);

    instr = 16'h0000; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("nop_done", done, 1);
    chk("nop_rw", RW, 0);
    @(negedge clk);
    chk("nop_rdy", instr_ready, 1);
    chk("nop_done2", done, 0);

    // reset during EXEC aborts the ADD into R5
    instr = rr(4'd3, 3'd5, 3'd1, 3'd2); instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk("abort_in_exec", busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_rw", RW, 0);
    chk("abort_rdy", instr_ready, 0);
    @(negedge clk);
    chk("abort_rw2", RW, 0);
    chk("abort_r5_kept", rf[5], 8'hA5);
    reset = 1'b1;
    #1;
    chk_init();
    chk("init_clr_r5", rf[5], 0);
    chk("init_clr_r7", rf[7], 0);

    // valid held high with four queued LDIs
    q[0] = ldi(3'd1, 8'h11); qd[0] = 8'h11;
    q[1] = ldi(3'd2, 8'h22); qd[1] = 8'h22;
    q[2] = ldi(3'd3, 8'h33); qd[2] = 8'h33;
    q[3] = ldi(3'd4, 8'h44); qd[3] = 8'h44;
    idx = 0; acc_n = 0; wr_n = 0; prev = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (RW) begin
        if (wr_n < 4) begin
          chk("q_da", DA, wr_n + 1);
          chk("q_wd", wr_data, qd[wr_n]);
        end else chk("q_extra_wr", 1, 0);
        wr_n++;
      end
      if (prev) idx++;
      instr_valid = (idx < 4);
      instr       = (idx < 4) ? q[idx] : 16'h0000;
      prev        = instr_valid && instr_ready;
      if (prev) begin
        acc_n++;
        chk("q_acc_idle", busy, 0);
      end
    end
    instr_valid = 1'b0;
    chk("q_accepts", acc_n, 4);
    chk("q_writes", wr_n, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
